pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameter REDIRECT_CYCLES, default 2: cycles decode stays flushed after a taken redirect (legal 1..7).
REQ-002 SHALL provide parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL use a single clock `clk`, and `reset` SHALL be synchronous and active-high.
REQ-004 SHALL provide these ports, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- i_dec_valid  in  1  decode holds a real instruction
- i_dec_rs1  in  5  decode source register 1
- i_dec_rs2  in  5  decode source register 2
- i_dec_uses_rs1  in  1  instruction reads rs1
- i_dec_uses_rs2  in  1  instruction reads rs2
- i_dec_rd  in  5  decode destination register
- i_dec_reg_wr_en  in  1  instruction writes rd
- i_dec_is_load  in  1  instruction is a load
- i_ex_redirect  in  1  execute resolved a taken branch or jump (PC select)
- o_stall_fetch  out  1  hold PC and the fetch/decode register
- o_stall_decode  out  1  hold the decode stage
- o_flush_decode  out  1  squash the decode-stage instruction
- o_flush_execute  out  1  squash the execute-stage instruction
- o_fwd_a_sel  out  2  execute operand A source: 00 regfile, 01 MEM result, 10 WB result
- o_fwd_b_sel  out  2  same encoding, operand B
- o_state  out  2  FSM state: 00 RUN, 01 LU_STALL, 10 REDIRECT
- o_stall_cnt  out  CNT_W  load-use stall cycles, saturating
- o_flush_cnt  out  CNT_W  redirect events, saturating

Function
REQ-005 SHALL keep three tracking slots, EX, MEM and WB, each holding {valid, rd, wr_en, is_load}; every clock MEM<=EX and WB<=MEM.
REQ-006 EX slot SHALL load the decode fields when i_dec_valid=1 and the cycle is neither a stall nor a flush; otherwise it SHALL load a bubble (valid=0).
REQ-007 A slot SHALL match register r only if valid=1, wr_en=1, rd==r and r!=0.
REQ-008 Load-use hazard (combinational) SHALL be: EX slot is_load=1 and matches (uses_rs1 and rs1) or (uses_rs2 and rs2), gated by i_dec_valid.
REQ-009 On a load-use hazard in RUN: o_stall_fetch=o_stall_decode=1 that cycle; EX gets a bubble; the next state SHALL be LU_STALL.
REQ-010 LU_STALL SHALL last exactly one cycle with no stall asserted (the load is now in MEM and forwardable from WB next cycle), then return to RUN unless a new hazard is present.
REQ-011 Forwarding selects SHALL be registered, computed from the instruction entering EX: sel=01 if the current EX slot matches and is_load=0; else sel=10 if the current MEM slot matches; else 00; computed per operand and gated by uses_rsX.
REQ-012 A WB-slot match SHALL need no forwarding (the register file is write-through).
REQ-013 When a stall or flush inserts a bubble, both fwd selects SHALL register 00.
REQ-014 i_ex_redirect=1 SHALL assert o_flush_decode and o_flush_execute combinationally that cycle, make EX a bubble, load the redirect counter with REDIRECT_CYCLES-1, and go to REDIRECT.
REQ-015 REDIRECT SHALL hold o_flush_decode=1 while the counter is nonzero, decrementing each cycle, then return to RUN.
REQ-016 Redirect SHALL take priority over a load-use stall in the same cycle: stalls deasserted, flushes asserted.
REQ-017 A new redirect arriving in REDIRECT SHALL reload the counter.
REQ-018 o_stall_cnt SHALL increment on each cycle o_stall_decode=1; o_flush_cnt SHALL increment on each i_ex_redirect cycle; both SHALL saturate at all-ones without wrapping.
REQ-019 Stalls and flushes SHALL be single-cycle combinational decisions; fwd selects SHALL have 1-cycle latency.

Reset
REQ-020 On reset: all slots invalid; state RUN; counter 0; o_fwd_*=00; o_stall_cnt=o_flush_cnt=0; o_stall_*=o_flush_*=0 (inputs ignored while reset=1).
REQ-021 Reset asserted mid-stall or mid-REDIRECT SHALL abandon the operation; the cycle after deassertion SHALL be RUN with no flush.

Verification
REQ-022 Load x5 in decode then add x6,x5,x7: cycle 2 stall=1 for exactly one cycle, EX bubble, then o_fwd_a_sel=10 when add is in EX; o_stall_cnt=1.
REQ-023 addi x5 then sub x8,x7,x5 back-to-back: no stall; o_fwd_b_sel=01 while sub is in EX.
REQ-024 Load writing x0 followed by a use of x0: no stall, fwd selects 00.
REQ-025 i_ex_redirect pulse with REDIRECT_CYCLES=2: flush_decode=1 for 2 cycles, flush_execute=1 for 1 cycle, o_flush_cnt=1; redirect coincident with a load-use hazard gives no stall.
REQ-026 Drive 2^CNT_W+3 stall cycles: o_stall_cnt holds at 0xFFFF; reset during REDIRECT gives state=00 and flushes low the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use interlock,
// EX/MEM operand forwarding selects and branch-redirect flushing.
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_CYCLES = 2,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_dec_valid,
    input  logic [4:0]       i_dec_rs1,
    input  logic [4:0]       i_dec_rs2,
    input  logic             i_dec_uses_rs1,
    input  logic             i_dec_uses_rs2,
    input  logic [4:0]       i_dec_rd,
    input  logic             i_dec_reg_wr_en,
    input  logic             i_dec_is_load,
    input  logic             i_ex_redirect,
    output logic             o_stall_fetch,
    output logic             o_stall_decode,
    output logic             o_flush_decode,
    output logic             o_flush_execute,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } slot_t;

    localparam logic [2:0] REDIRECT_RELOAD = 3'(REDIRECT_CYCLES - 1);

    function automatic logic slot_match(input slot_t s, input logic [4:0] r);
        return s.valid && s.wr_en && (s.rd == r) && (r != 5'd0);
    endfunction

    state_t           state_reg, state_next;
    logic [2:0]       rcnt_reg, rcnt_next;
    // The instruction leaving MEM retires through a write-through register
    // file, so its identity is never consulted and only EX/MEM are stored.
    slot_t            ex_reg, mem_reg;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             hazard, stall, flush_dec, ex_bubble;

    assign hazard = i_dec_valid && ex_reg.is_load &&
                    ((i_dec_uses_rs1 && slot_match(ex_reg, i_dec_rs1)) ||
                     (i_dec_uses_rs2 && slot_match(ex_reg, i_dec_rs2)));

    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        stall      = 1'b0;
        flush_dec  = 1'b0;
        if (i_ex_redirect) begin
            flush_dec  = 1'b1;
            rcnt_next  = REDIRECT_RELOAD;
            state_next = ST_REDIRECT;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (hazard) begin
                        stall      = 1'b1;
                        state_next = ST_LU_STALL;
                    end
                end
                ST_LU_STALL: begin
                    state_next = ST_RUN;
                end
                ST_REDIRECT: begin
                    if (rcnt_reg != 3'd0) begin
                        flush_dec = 1'b1;
                        rcnt_next = rcnt_reg - 3'd1;
                        if (rcnt_reg == 3'd1) begin
                            state_next = ST_RUN;
                        end
                    end else begin
                        state_next = ST_RUN;
                        if (hazard) begin
                            stall      = 1'b1;
                            state_next = ST_LU_STALL;
                        end
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign ex_bubble = stall || flush_dec || !i_dec_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            rcnt_reg      <= 3'd0;
            ex_reg        <= '0;
            mem_reg       <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            rcnt_reg  <= rcnt_next;
            mem_reg   <= ex_reg;
            ex_reg    <= ex_bubble ? slot_t'('0)
                                   : slot_t'{1'b1, i_dec_rd, i_dec_reg_wr_en, i_dec_is_load};
            if (stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (i_ex_redirect && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    // One forwarding mux per operand; a producing load in EX is never a
    // forward source because the interlock has already bubbled the consumer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [4:0] rs;
            logic       use_rs;
            logic [1:0] sel_next, sel_reg;

            assign rs     = (gi == 0) ? i_dec_rs1 : i_dec_rs2;
            assign use_rs = (gi == 0) ? i_dec_uses_rs1 : i_dec_uses_rs2;

            always_comb begin
                sel_next = 2'b00;
                if (!ex_bubble && use_rs) begin
                    if (slot_match(ex_reg, rs) && !ex_reg.is_load) begin
                        sel_next = 2'b01;
                    end else if (slot_match(mem_reg, rs)) begin
                        sel_next = 2'b10;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sel_reg <= 2'b00;
                end else begin
                    sel_reg <= sel_next;
                end
            end
        end
    endgenerate

    assign o_stall_fetch   = stall && !reset;
    assign o_stall_decode  = stall && !reset;
    assign o_flush_decode  = flush_dec && !reset;
    assign o_flush_execute = i_ex_redirect && !reset;
    assign o_fwd_a_sel     = g_fwd[0].sel_reg;
    assign o_fwd_b_sel     = g_fwd[1].sel_reg;
    assign o_state         = state_reg;
    assign o_stall_cnt     = stall_cnt_reg;
    assign o_flush_cnt     = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: an instruction-level pipeline
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int RC   = 2;
    localparam int W    = 8;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_dec_valid;
    logic [4:0]   i_dec_rs1, i_dec_rs2, i_dec_rd;
    logic         i_dec_uses_rs1, i_dec_uses_rs2;
    logic         i_dec_reg_wr_en, i_dec_is_load, i_ex_redirect;
    logic         o_stall_fetch, o_stall_decode, o_flush_decode, o_flush_execute;
    logic [1:0]   o_fwd_a_sel, o_fwd_b_sel, o_state;
    logic [W-1:0] o_stall_cnt, o_flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REDIRECT_CYCLES(RC), .CNT_W(W)) dut (
        .clk(clk), .reset(reset),
        .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
        .i_dec_uses_rs1(i_dec_uses_rs1), .i_dec_uses_rs2(i_dec_uses_rs2),
        .i_dec_rd(i_dec_rd), .i_dec_reg_wr_en(i_dec_reg_wr_en),
        .i_dec_is_load(i_dec_is_load), .i_ex_redirect(i_ex_redirect),
        .o_stall_fetch(o_stall_fetch), .o_stall_decode(o_stall_decode),
        .o_flush_decode(o_flush_decode), .o_flush_execute(o_flush_execute),
        .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel), .o_state(o_state),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    function automatic bit writes(input instr_t s, input int r);
        return s.v && s.wr && (s.rd == r) && (r != 0);
    endfunction

    // Where an operand entering EX gets its value from.
    function automatic int src(input instr_t ex, input instr_t mem, input bit use_r, input int r);
        if (!use_r) return 0;
        if (writes(ex, r) && !ex.ld) return 1;
        if (writes(mem, r)) return 2;
        return 0;
    endfunction

    initial begin : model
        instr_t m_ex, m_mem, nx;
        bit     m_lu, hz, flushing, stl, bub;
        int     m_left, m_fa, m_fb, m_sc, m_fc, e_state;
        m_ex   = '{default: 0};
        m_mem  = '{default: 0};
        m_lu   = 0;
        m_left = 0;
        m_fa   = 0;
        m_fb   = 0;
        m_sc   = 0;
        m_fc   = 0;
        forever begin
            @(negedge clk);
            hz = 0;
            flushing = 0;
            stl = 0;
            if (!reset) begin
                hz = i_dec_valid && m_ex.ld &&
                     ((i_dec_uses_rs1 && writes(m_ex, int'(i_dec_rs1))) ||
                      (i_dec_uses_rs2 && writes(m_ex, int'(i_dec_rs2))));
                flushing = i_ex_redirect || (m_left > 0);
                stl = hz && !flushing && !m_lu;
            end
            e_state = m_lu ? 1 : ((m_left > 0) ? 2 : 0);
            chk("stall_fetch", o_stall_fetch, stl);
            chk("stall_decode", o_stall_decode, stl);
            chk("flush_decode", o_flush_decode, flushing);
            chk("flush_execute", o_flush_execute, !reset && i_ex_redirect);
            chk("state", o_state, e_state);
            chk("fwd_a", o_fwd_a_sel, m_fa);
            chk("fwd_b", o_fwd_b_sel, m_fb);
            chk("stall_cnt", o_stall_cnt, m_sc);
            chk("flush_cnt", o_flush_cnt, m_fc);
            if (reset) begin
                m_ex   = '{default: 0};
                m_mem  = '{default: 0};
                m_lu   = 0;
                m_left = 0;
                m_fa   = 0;
                m_fb   = 0;
                m_sc   = 0;
                m_fc   = 0;
            end else begin
                bub  = stl || flushing || !i_dec_valid;
                m_fa = bub ? 0 : src(m_ex, m_mem, i_dec_uses_rs1, int'(i_dec_rs1));
                m_fb = bub ? 0 : src(m_ex, m_mem, i_dec_uses_rs2, int'(i_dec_rs2));
                nx.v  = !bub;
                nx.rd = int'(i_dec_rd);
                nx.wr = i_dec_reg_wr_en;
                nx.ld = i_dec_is_load;
                m_mem = m_ex;
                m_ex  = bub ? '{default: 0} : nx;
                if (stl && m_sc < CMAX) m_sc++;
                if (i_ex_redirect && m_fc < CMAX) m_fc++;
                m_left = i_ex_redirect ? RC - 1 : ((m_left > 0) ? m_left - 1 : 0);
                m_lu   = stl;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_dec(input bit v, input int r1, input bit u1, input int r2,
                           input bit u2, input int rd, input bit wr, input bit ld);
        i_dec_valid     = v;
        i_dec_rs1       = 5'(r1);
        i_dec_uses_rs1  = u1;
        i_dec_rs2       = 5'(r2);
        i_dec_uses_rs2  = u2;
        i_dec_rd        = 5'(rd);
        i_dec_reg_wr_en = wr;
        i_dec_is_load   = ld;
    endtask

    task automatic nop();                            set_dec(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lw(input int rd, input int rs1);  set_dec(1, rs1, 1, 0, 0, rd, 1, 1); endtask
    task automatic addi(input int rd, input int rs1); set_dec(1, rs1, 1, 0, 0, rd, 1, 0); endtask
    task automatic alu(input int rd, input int rs1, input int rs2);
        set_dec(1, rs1, 1, rs2, 1, rd, 1, 0);
    endtask

    task automatic step(input string name);
        $display("txn %-12s t=%0t rst=%0b v=%0b rs1=%0d rs2=%0d rd=%0d ld=%0b redir=%0b",
                 name, $time, reset, i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd,
                 i_dec_is_load, i_ex_redirect);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin : drive
        int stalls;
        reset = 1'b1;
        i_ex_redirect = 1'b1;
        lw(5, 5);
        step("reset_busy");
        chk("rst_flush_exec", o_flush_execute, 0);
        chk("rst_stall", o_stall_decode, 0);
        tick();
        step("reset_busy");
        tick();
        reset = 1'b0;
        i_ex_redirect = 1'b0;
        nop();
        step("idle");
        chk("rst_state", o_state, 0);
        chk("rst_fwd_a", o_fwd_a_sel, 0);
        chk("rst_stall_cnt", o_stall_cnt, 0);
        chk("rst_flush_cnt", o_flush_cnt, 0);
        tick();

        // load x5 ; add x6,x5,x7
        lw(5, 1);      step("lw_x5");       chk("lu_no_early_stall", o_stall_decode, 0); tick();
        alu(6, 5, 7);  step("add_x6_x5");   chk("lu_stall_fetch", o_stall_fetch, 1);
                                            chk("lu_stall_decode", o_stall_decode, 1); tick();
        step("add_hold");                   chk("lu_stall_once", o_stall_decode, 0);
                                            chk("lu_state", o_state, 1); tick();
        nop();         step("idle");        chk("lu_fwd_a_wb", o_fwd_a_sel, 2);
                                            chk("lu_fwd_b", o_fwd_b_sel, 0);
                                            chk("lu_stall_cnt", o_stall_cnt, 1);
                                            chk("lu_state_run", o_state, 0); tick();

        // addi x5 ; sub x8,x7,x5
        addi(5, 1);    step("addi_x5");     tick();
        alu(8, 7, 5);  step("sub_x8");      chk("alu_no_stall", o_stall_decode, 0); tick();
        nop();         step("idle");        chk("alu_fwd_b_mem", o_fwd_b_sel, 1);
                                            chk("alu_fwd_a", o_fwd_a_sel, 0); tick();

        // load to x0 then read x0
        lw(0, 2);      step("lw_x0");       tick();
        alu(9, 0, 0);  step("add_x0");      chk("x0_no_stall", o_stall_decode, 0); tick();
        nop();         step("idle");        chk("x0_fwd_a", o_fwd_a_sel, 0);
                                            chk("x0_fwd_b", o_fwd_b_sel, 0); tick();

        // producer two ahead forwards from WB; nearest producer wins
        addi(10, 1);   step("addi_x10");    tick();
        nop();         step("idle");        tick();
        alu(14, 10, 3); step("use_x10");    tick();
        addi(11, 1);   step("addi_x11_a");  chk("fwd_a_two_back", o_fwd_a_sel, 2); tick();
        addi(11, 2);   step("addi_x11_b");  tick();
        alu(15, 3, 11); step("use_x11");    tick();
        set_dec(1, 11, 0, 11, 0, 16, 1, 0);
        step("unused_rs");                  chk("fwd_b_nearest", o_fwd_b_sel, 1); tick();
        nop();         step("idle");        chk("fwd_gated_a", o_fwd_a_sel, 0);
                                            chk("fwd_gated_b", o_fwd_b_sel, 0); tick();

        // redirect pulse
        i_ex_redirect = 1'b1;
        step("redirect");                   chk("rd_flush_dec0", o_flush_decode, 1);
                                            chk("rd_flush_exe0", o_flush_execute, 1); tick();
        i_ex_redirect = 1'b0;
        step("redir_hold");                 chk("rd_flush_dec1", o_flush_decode, 1);
                                            chk("rd_flush_exe1", o_flush_execute, 0);
                                            chk("rd_state", o_state, 2); tick();
        step("idle");                       chk("rd_flush_dec2", o_flush_decode, 0);
                                            chk("rd_state_run", o_state, 0);
                                            chk("rd_flush_cnt", o_flush_cnt, 1); tick();

        // redirect coincident with a load-use hazard
        lw(5, 1);      step("lw_x5");       tick();
        alu(6, 5, 7);
        i_ex_redirect = 1'b1;
        step("use+redirect");               chk("co_no_stall_f", o_stall_fetch, 0);
                                            chk("co_no_stall_d", o_stall_decode, 0);
                                            chk("co_flush_dec", o_flush_decode, 1);
                                            chk("co_flush_exe", o_flush_execute, 1); tick();
        i_ex_redirect = 1'b0;
        nop();         step("idle");        tick();
        step("idle");                       chk("co_stall_cnt", o_stall_cnt, 1);
                                            chk("co_flush_cnt", o_flush_cnt, 2); tick();

        // redirect arriving inside REDIRECT reloads the count
        i_ex_redirect = 1'b1; step("redirect"); tick();
        step("redirect_again"); tick();
        i_ex_redirect = 1'b0;
        step("redir_hold");                 chk("rl_flush_dec", o_flush_decode, 1);
                                            chk("rl_state", o_state, 2); tick();
        step("idle");                       chk("rl_flush_done", o_flush_decode, 0);
                                            chk("rl_flush_cnt", o_flush_cnt, 4); tick();

        // saturation: self-dependent load held in decode stalls every other cycle
        $display("txn %-12s t=%0t hold lw x5,0(x5) for 530 cycles", "sat_burst", $time);
        stalls = 0;
        lw(5, 5);
        for (int i = 0; i < 530; i++) begin
            @(negedge clk);
            if (o_stall_decode === 1'b1) stalls++;
            tick();
        end
        nop();
        step("idle");                       chk("sat_stall_cycles", stalls, 265);
                                            chk("sat_stall_cnt", o_stall_cnt, CMAX); tick();

        // reset while in REDIRECT
        i_ex_redirect = 1'b1; step("redirect"); tick();
        i_ex_redirect = 1'b0;
        reset = 1'b1;
        step("reset_in_redir");             chk("rr_state_before", o_state, 2);
                                            chk("rr_flush_gated", o_flush_decode, 0); tick();
        reset = 1'b0;
        step("idle");                       chk("rr_state", o_state, 0);
                                            chk("rr_flush_dec", o_flush_decode, 0);
                                            chk("rr_flush_exe", o_flush_execute, 0);
                                            chk("rr_stall_cnt", o_stall_cnt, 0); tick();

        // reset while in LU_STALL
        lw(7, 1);      step("lw_x7");       tick();
        alu(8, 7, 7);  step("use_x7");      chk("rs_stall", o_stall_decode, 1); tick();
        reset = 1'b1;  step("reset_in_lu"); chk("rs_state_before", o_state, 1); tick();
        reset = 1'b0;  nop();
        step("idle");                       chk("rs_state", o_state, 0);
                                            chk("rs_fwd_a", o_fwd_a_sel, 0); tick();

        // mixed traffic on a small register set, checked by the model
        $display("txn %-12s t=%0t 300 cycles mixed traffic", "random_burst", $time);
        for (int i = 0; i < 300; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            i_ex_redirect = ($urandom_range(0, 7) == 0);
            set_dec($urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            tick();
        end
        reset = 1'b0;
        i_ex_redirect = 1'b0;
        nop();
        repeat (3) tick();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
